// File: rtl/pwr_domain_iso_sequencer.sv
// Isolation / retention / power-switch sequencer for one switchable domain.
// Optional retention handshake enabled by defining PWR_ISO_SEQ_RETENTION_EN.
module pwr_domain_iso_sequencer #(
    parameter int ISO_SETUP_CYC = 3,
    parameter int ACK_TIMEOUT   = 16,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_off,
    input  logic req_on,
    input  logic pwr_ack,
    output logic iso_en,
    output logic ret_save,
    output logic ret_restore,
    output logic pwr_sw_en,
    output logic busy,
    output logic done,
    output logic err_timeout
);

    typedef enum logic [3:0] {
        S_ON,
        S_ISO_ASSERT,
`ifdef PWR_ISO_SEQ_RETENTION_EN
        S_SAVE,
        S_RESTORE,
`endif
        S_PWR_OFF_WAIT,
        S_OFF,
        S_PWR_ON_WAIT,
        S_ISO_RELEASE,
        S_FAULT
    } state_t;

    // A hold or timeout of N cycles ends on the cycle where cnt reaches N-1.
    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              iso_en_q, iso_en_d;
    logic              pwr_sw_en_q, pwr_sw_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_timeout_q, err_timeout_d;
`ifdef PWR_ISO_SEQ_RETENTION_EN
    logic              ret_save_q, ret_save_d;
    logic              ret_restore_q, ret_restore_d;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ON:          if (req_off) state_d = S_ISO_ASSERT;
            S_ISO_ASSERT: begin
                if (cnt_q == ISO_LAST) begin
`ifdef PWR_ISO_SEQ_RETENTION_EN
                    state_d = S_SAVE;
`else
                    state_d = S_PWR_OFF_WAIT;
`endif
                end
            end
`ifdef PWR_ISO_SEQ_RETENTION_EN
            S_SAVE:        state_d = S_PWR_OFF_WAIT;
            S_RESTORE:     state_d = S_ISO_RELEASE;
`endif
            S_PWR_OFF_WAIT: begin
                if (!pwr_ack)               state_d = S_OFF;
                else if (cnt_q == ACK_LAST) state_d = S_FAULT;
            end
            S_OFF:         if (req_on) state_d = S_PWR_ON_WAIT;
            S_PWR_ON_WAIT: begin
                if (pwr_ack) begin
`ifdef PWR_ISO_SEQ_RETENTION_EN
                    state_d = S_RESTORE;
`else
                    state_d = S_ISO_RELEASE;
`endif
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_ISO_RELEASE: if (cnt_q == ISO_LAST) state_d = S_ON;
            S_FAULT:       state_d = S_FAULT;
            // Unused encodings land in FAULT so the crossing stays clamped.
            default:       state_d = S_FAULT;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (&cnt_q)        cnt_d = cnt_q;
        else                    cnt_d = cnt_q + 1'b1;

        // Outputs are decoded from the next state so they change on state entry.
        iso_en_d = (state_d != S_ON);
        case (state_d)
            S_PWR_OFF_WAIT, S_OFF: pwr_sw_en_d = 1'b0;
            S_FAULT:               pwr_sw_en_d = pwr_sw_en_q;
            default:               pwr_sw_en_d = 1'b1;
        endcase
        busy_d = !(state_d == S_ON || state_d == S_OFF || state_d == S_FAULT);
        done_d = (state_d == S_ON  && state_q == S_ISO_RELEASE) ||
                 (state_d == S_OFF && state_q == S_PWR_OFF_WAIT);
        err_timeout_d = err_timeout_q | (state_d == S_FAULT);
`ifdef PWR_ISO_SEQ_RETENTION_EN
        ret_save_d    = (state_d == S_SAVE);
        ret_restore_d = (state_d == S_RESTORE);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_ON;
            cnt_q         <= '0;
            iso_en_q      <= 1'b0;
            pwr_sw_en_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef PWR_ISO_SEQ_RETENTION_EN
            ret_save_q    <= 1'b0;
            ret_restore_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            iso_en_q      <= iso_en_d;
            pwr_sw_en_q   <= pwr_sw_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
`ifdef PWR_ISO_SEQ_RETENTION_EN
            ret_save_q    <= ret_save_d;
            ret_restore_q <= ret_restore_d;
`endif
        end
    end

    assign iso_en      = iso_en_q;
    assign pwr_sw_en   = pwr_sw_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
`ifdef PWR_ISO_SEQ_RETENTION_EN
    assign ret_save    = ret_save_q;
    assign ret_restore = ret_restore_q;
`else
    assign ret_save    = 1'b0;
    assign ret_restore = 1'b0;
`endif

endmodule

// File: tb/tb_pwr_domain_iso_sequencer.sv
// Directed bench for pwr_domain_iso_sequencer (ISO_SETUP_CYC=3, ACK_TIMEOUT=16).
// Follows PWR_ISO_SEQ_RETENTION_EN the same way the design does.
module tb_pwr_domain_iso_sequencer;

    logic clk = 1'b0;
    logic rst, req_off, req_on, pwr_ack;
    logic iso_en, ret_save, ret_restore, pwr_sw_en, busy, done, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    string      tag_q[$];
    logic [6:0] exp_q[$];

    // Vector order: {iso_en, ret_save, ret_restore, pwr_sw_en, busy, done, err_timeout}
    localparam logic [6:0] ON_V     = 7'b0001000;
    localparam logic [6:0] ON_DONE  = 7'b0001010;
    localparam logic [6:0] BUSY_ON  = 7'b1001100;
    localparam logic [6:0] SAVE_V   = 7'b1101100;
    localparam logic [6:0] REST_V   = 7'b1011100;
    localparam logic [6:0] POW_V    = 7'b1000100;
    localparam logic [6:0] OFF_V    = 7'b1000000;
    localparam logic [6:0] OFF_DONE = 7'b1000010;
    localparam logic [6:0] FAULT_V  = 7'b1000001;

    pwr_domain_iso_sequencer #(
        .ISO_SETUP_CYC(3),
        .ACK_TIMEOUT(16),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_off(req_off),
        .req_on(req_on),
        .pwr_ack(pwr_ack),
        .iso_en(iso_en),
        .ret_save(ret_save),
        .ret_restore(ret_restore),
        .pwr_sw_en(pwr_sw_en),
        .busy(busy),
        .done(done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        string      tag;
        logic [6:0] e;
        logic [6:0] obs;
        tag = tag_q.pop_front();
        e   = exp_q.pop_front();
        obs = {iso_en, ret_save, ret_restore, pwr_sw_en, busy, done, err_timeout};
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    // Drive inputs for one clock, queue the expected post-edge outputs, then compare.
    task automatic step(input logic r, input logic ro, input logic ri, input logic ack,
                        input logic [6:0] e, input string tag);
        rst = r; req_off = ro; req_on = ri; pwr_ack = ack;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic iso_assert_phase();
        step(0, 1, 0, 1, BUSY_ON, "iso_assert_entry");
        step(0, 0, 1, 1, BUSY_ON, "iso_assert_reqon_dropped");
        step(0, 0, 0, 1, BUSY_ON, "iso_assert_hold");
`ifdef PWR_ISO_SEQ_RETENTION_EN
        step(0, 0, 0, 1, SAVE_V, "save_pulse");
`endif
    endtask

    task automatic on_tail(input logic ack_at_entry);
        step(0, 1, 1, ack_at_entry, BUSY_ON, "pwr_on_wait_entry_both_req");
`ifdef PWR_ISO_SEQ_RETENTION_EN
        step(0, 0, 0, 1, REST_V, "restore_pulse");
        step(0, 0, 0, 1, BUSY_ON, "iso_release_1");
`else
        step(0, 0, 0, 1, BUSY_ON, "iso_release_1");
`endif
        step(0, 0, 0, 1, BUSY_ON, "iso_release_2");
        step(0, 0, 0, 1, BUSY_ON, "iso_release_3");
        step(0, 0, 0, 1, ON_DONE, "on_done");
        step(0, 0, 1, 1, ON_V, "on_idle_no_done");
    endtask

    initial begin
        rst = 1'b1; req_off = 1'b0; req_on = 1'b0; pwr_ack = 1'b1;

        step(1, 0, 0, 1, ON_V, "reset_1");
        step(1, 0, 0, 1, ON_V, "reset_2");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, ON_V, "idle_after_reset");

        // Normal power-down: ack falls two cycles after the switch opens.
        iso_assert_phase();
        step(0, 0, 0, 1, POW_V, "pwr_off_entry");
        step(0, 0, 0, 1, POW_V, "pwr_off_wait_1");
        step(0, 0, 0, 1, POW_V, "pwr_off_wait_2");
        step(0, 0, 0, 0, OFF_DONE, "off_done");
        step(0, 1, 0, 0, OFF_V, "off_reqoff_dropped");

        // Normal power-up: ack rises at the third wait cycle.
        step(0, 1, 1, 0, BUSY_ON, "pwr_on_entry_both_req");
        step(0, 0, 0, 0, BUSY_ON, "pwr_on_wait_1");
        step(0, 0, 0, 0, BUSY_ON, "pwr_on_wait_2");
`ifdef PWR_ISO_SEQ_RETENTION_EN
        step(0, 0, 0, 1, REST_V, "restore_pulse");
        step(0, 0, 0, 1, BUSY_ON, "iso_release_1");
`else
        step(0, 0, 0, 1, BUSY_ON, "iso_release_1");
`endif
        step(0, 0, 0, 1, BUSY_ON, "iso_release_2");
        step(0, 0, 0, 1, BUSY_ON, "iso_release_3");
        step(0, 0, 0, 1, ON_DONE, "on_done");
        step(0, 0, 0, 1, ON_V, "on_idle");

        // Ack already at target on wait-state entry: one wait cycle only.
        iso_assert_phase();
        step(0, 0, 0, 0, POW_V, "pwr_off_entry_ack_low");
        step(0, 0, 0, 0, OFF_DONE, "off_done_early_ack");
        on_tail(1'b1);

        // Stuck ack: 16 cycles in the off-wait, then FAULT.
        iso_assert_phase();
        step(0, 0, 0, 1, POW_V, "stuck_pwr_off_entry");
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, POW_V, "stuck_pwr_off_wait");
        step(0, 0, 0, 1, FAULT_V, "fault_entry");
        step(0, 0, 1, 1, FAULT_V, "fault_reqon_ignored");
        step(0, 1, 0, 0, FAULT_V, "fault_reqoff_ignored");
        step(0, 1, 1, 1, FAULT_V, "fault_hold");
        step(1, 0, 0, 1, ON_V, "fault_cleared_by_rst");

        // Reset mid-sequence aborts to ON; req_on in ON is dropped.
        step(0, 1, 0, 1, BUSY_ON, "abort_iso_assert");
        step(1, 0, 1, 1, ON_V, "abort_rst");
        step(0, 0, 1, 1, ON_V, "on_reqon_ignored_1");
        step(0, 0, 1, 1, ON_V, "on_reqon_ignored_2");
        step(0, 0, 0, 1, ON_V, "on_quiet");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
